// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Build option: define PUF_SEQ_VOTE_EN for three reads per challenge with 2-of-3 voting.
package puf_pkg;

  localparam int unsigned RSP_W         = 6;
  localparam int unsigned IDX_W         = 8;
  localparam logic [31:0] LFSR_POLY_DEF = 32'h80200003;

`ifdef PUF_SEQ_VOTE_EN
  localparam int unsigned READS = 3;
`else
  localparam int unsigned READS = 1;
`endif

  localparam int unsigned RD_W  = 2;
  localparam int unsigned CNT_W = RD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EVAL,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [RSP_W-1:0] stable;
    logic [RSP_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/puf_lfsr.sv
// 32-bit Galois LFSR holding the current challenge; load wins over advance.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY_DEF
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  // Challenge register: load a new seed or step once
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (adv) begin
      state <= (state >> 1) ^ (state[0] ? POLY : 32'h0);
    end
  end

endmodule

// File: rtl/puf_seq.sv
// PUF challenge sequencer: issues LFSR challenges, collects reads, votes,
// and hands responses out over a valid/ready port.
// Build option: PUF_SEQ_VOTE_EN selects three reads per challenge.
module puf_seq
  import puf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [31:0] LFSR_POLY   = LFSR_POLY_DEF
) (
  input  logic             clk50,
  input  logic             arst_clk50,
  input  logic             start_i,
  input  logic [31:0]      seed_i,
  input  logic [7:0]       num_chal_i,
  input  logic [3:0]       wait_cyc_i,
  output logic             puf_req_o,
  output logic [31:0]      puf_sel_o,
  output logic [3:0]       puf_wait_cyc_o,
  input  logic             puf_busy_i,
  input  logic             puf_valid_i,
  input  logic [RSP_W-1:0] puf_q_i,
  input  logic [RSP_W-1:0] puf_qn_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [RSP_W-1:0] rsp_data_o,
  output logic [RSP_W-1:0] rsp_stable_o,
  output logic [7:0]       rsp_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       rst_sync;
  logic             rst;
  state_t           state;
  logic [7:0]       chal_cnt;
  logic [7:0]       idx;
  logic [3:0]       wait_cyc;
  logic [RD_W-1:0]  rd_cnt;
  logic [TO_W-1:0]  timer;
  logic [RSP_W-1:0] q_cap  [READS];
  logic [RSP_W-1:0] qn_cap [READS];
  rsp_t             rsp_r;
  logic [31:0]      chal;
  logic [31:0]      seed_c;
  logic             lfsr_load_c;
  logic             lfsr_adv_c;
  logic [RSP_W-1:0] eval_data_c;
  logic [RSP_W-1:0] eval_stable_c;
  logic [CNT_W-1:0] ones;

  // Reset asserts immediately, releases two clk50 edges later
  always_ff @(posedge clk50 or posedge arst_clk50) begin
    if (arst_clk50) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst = rst_sync[1];

  // A zero seed would lock the LFSR, so it is replaced by 1
  assign seed_c      = (seed_i == 32'h0) ? 32'h1 : seed_i;
  assign lfsr_load_c = (state == IDLE) && start_i;
  assign lfsr_adv_c  = (state == OUT) && rsp_ready_i;

  puf_lfsr #(
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk50 (clk50),
    .rst   (rst),
    .load  (lfsr_load_c),
    .adv   (lfsr_adv_c),
    .seed  (seed_c),
    .state (chal)
  );

  // Per-bit majority of the captured reads and agreement/complement check
  always_comb begin
    eval_data_c   = '0;
    eval_stable_c = '1;
    ones          = '0;
    for (int b = 0; b < RSP_W; b++) begin
      ones = '0;
      for (int r = 0; r < READS; r++) begin
        ones = ones + CNT_W'(q_cap[r][b]);
        if (q_cap[r][b] == qn_cap[r][b]) eval_stable_c[b] = 1'b0;
        if (q_cap[r][b] != q_cap[0][b])  eval_stable_c[b] = 1'b0;
      end
      eval_data_c[b] = (ones > CNT_W'(READS / 2));
    end
  end

  assign rsp_data_o   = rsp_r.data;
  assign rsp_stable_o = rsp_r.stable;
  assign rsp_idx_o    = rsp_r.idx;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      chal_cnt       <= '0;
      idx            <= '0;
      wait_cyc       <= '0;
      rd_cnt         <= '0;
      timer          <= '0;
      rsp_r          <= '0;
      puf_req_o      <= 1'b0;
      puf_sel_o      <= '0;
      puf_wait_cyc_o <= '0;
      rsp_valid_o    <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      for (int r = 0; r < READS; r++) begin
        q_cap[r]  <= '0;
        qn_cap[r] <= '0;
      end
    end else begin
      puf_req_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            chal_cnt <= num_chal_i;
            wait_cyc <= wait_cyc_i;
            err_o    <= 1'b0;
            idx      <= '0;
            rd_cnt   <= '0;
            busy_o   <= 1'b1;
            state    <= (num_chal_i == 8'd0) ? DONE : REQ;
          end
        end
        REQ: begin
          if (!puf_busy_i) begin
            puf_req_o      <= 1'b1;
            puf_sel_o      <= chal;
            puf_wait_cyc_o <= wait_cyc;
            timer          <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (puf_valid_i) begin
            for (int r = 0; r < READS; r++) begin
              if (rd_cnt == RD_W'(r)) begin
                q_cap[r]  <= puf_q_i;
                qn_cap[r] <= puf_qn_i;
              end
            end
            if (rd_cnt == RD_W'(READS - 1)) begin
              rd_cnt <= '0;
              state  <= EVAL;
            end else begin
              rd_cnt <= rd_cnt + RD_W'(1);
              state  <= REQ;
            end
          end else if (timer == TO_W'(TIMEOUT_CYC - 1)) begin
            err_o  <= 1'b1;
            rd_cnt <= '0;
            state  <= DONE;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
        EVAL: begin
          rsp_r.data   <= eval_data_c;
          rsp_r.stable <= eval_stable_c;
          rsp_r.idx    <= idx;
          rsp_valid_o  <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            idx         <= idx + 8'd1;
            state       <= (({1'b0, idx} + 9'd1) == {1'b0, chal_cnt}) ? DONE : REQ;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_seq.md
PUF_SEQ -- requirements
Module: puf_seq

Interface
REQ-001 SHALL have parameters: TIMEOUT_CYC, 64, max clk50 cycles from puf_req_o to puf_valid_i; LFSR_POLY, 32'h80200003, Galois feedback mask for challenge generation.
REQ-002 SHALL have ports: clk50 in 1, single clock; arst_clk50 in 1, reset is asynchronous and active-high.
REQ-003 SHALL have ports: start_i in 1, run pulse; seed_i in 32, first challenge; num_chal_i in 8, challenge count; wait_cyc_i in 4, PUF settle setting.
REQ-004 SHALL have ports: puf_req_o out 1; puf_sel_o out 32; puf_wait_cyc_o out 4; puf_busy_i in 1; puf_valid_i in 1; puf_q_i in 6; puf_qn_i in 6.
REQ-005 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_data_o out 6; rsp_stable_o out 6; rsp_idx_o out 8.
REQ-006 SHALL have ports: busy_o out 1, high from accepted start to done; done_o out 1, one-cycle pulse at run end; err_o out 1, sticky timeout flag.

Function
REQ-007 SHALL use FSM states IDLE, REQ, WAIT, EVAL, OUT, DONE.
REQ-008 IDLE: start_i high SHALL latch seed_i (0 replaced by 32'h1), num_chal_i, wait_cyc_i, clear err_o and the index, set busy_o, go to REQ; start_i while busy_o is high SHALL be ignored.
REQ-009 num_chal_i = 0 at start SHALL go directly to DONE with no PUF request.
REQ-010 REQ: when puf_busy_i is low, SHALL drive puf_req_o high for exactly one cycle with puf_sel_o = current challenge, then go to WAIT; puf_sel_o and puf_wait_cyc_o SHALL stay constant from the request until puf_valid_i.
REQ-011 WAIT: puf_valid_i SHALL capture puf_q_i/puf_qn_i; if the read count is below READS, go to REQ, otherwise go to EVAL.
REQ-012 WAIT: a timeout counter SHALL reach TIMEOUT_CYC without puf_valid_i -> set err_o, go to DONE, emit no response for that challenge.
REQ-013 EVAL, one cycle: rsp_data_o[i] SHALL be the majority of captured q[i]; rsp_stable_o[i] SHALL be 1 iff every read has q[i] != qn[i] and all reads agree.
REQ-014 OUT: rsp_valid_o SHALL stay high with rsp_data_o, rsp_stable_o and rsp_idx_o held constant until rsp_ready_i; on the handshake the LFSR advances one step, the index increments, and the FSM goes to REQ, or to DONE if index+1 == count.
REQ-015 The LFSR step SHALL be: s' = (s >> 1) ^ (s[0] ? LFSR_POLY : 0); challenge k is the seed advanced k steps.
REQ-016 DONE: SHALL pulse done_o for one cycle, clear busy_o, return to IDLE.
REQ-017 rsp_idx_o SHALL be the 0-based challenge index, 8 bits wide; count 255 SHALL be the maximum and the index SHALL not wrap.
REQ-018 puf_valid_i outside WAIT SHALL be ignored.

Reset
REQ-019 arst_clk50 asserted SHALL immediately force IDLE and zero every output, LFSR state, counter and capture register, including mid-run; deassertion SHALL be synchronised internally to clk50.

Configuration
REQ-020 Macro PUF_SEQ_VOTE_EN defined SHALL set READS = 3 (three reads per challenge, bitwise 2-of-3 majority); undefined SHALL set READS = 1 (data = q, stable = q ^ qn); port list identical in both builds.

Structure
REQ-021 A shared package puf_pkg SHALL hold the FSM state enum, LFSR_POLY default, READS derivation and response width (6).
REQ-022 One sub-module puf_lfsr (32-bit Galois step with load and advance enable) SHALL be instantiated; all else inline.

Verification
REQ-023 Single read, seed 32'h1, count 2, PUF model returns q=6'h2A qn=6'h15 -> two responses data 2A stable 3F, idx 0,1; second sel 32'h80200003; one done_o pulse.
REQ-024 Vote build, reads q=2A,2A,0A with qn complementary -> data 2A, stable 1F (bit5 disagreed); exactly three puf_req_o pulses per challenge.
REQ-025 Model never asserts valid -> after 64 cycles err_o=1, done_o pulse, no rsp_valid_o; next start clears err_o.
REQ-026 rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable throughout, no new puf_req_o; count 0 -> done_o within 2 cycles, no request.
REQ-027 arst_clk50 pulsed during WAIT, and start_i pulsed while busy_o is high -> outputs zero/IDLE after reset; the busy-time start causes no restart.
